// File: rtl/palette_pkg.sv
// Shared constants, CPU-port FSM state type and width helpers for the palette RAM block.
package palette_pkg;

    // Default geometry: 1K x 16 palette, four 8-bit pixel sources.
    localparam int unsigned DefAddrW   = 10;
    localparam int unsigned DefDataW   = 16;
    localparam int unsigned DefNumSrc  = 4;
    localparam int unsigned DefSrcW    = 8;
    localparam int unsigned DefMaxWait = 8;

    // CPU request handshake states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } cpu_state_e;

    // Width of the bank field that sits above the per-source index.
    function automatic int unsigned bank_width(input int unsigned addr_w,
                                               input int unsigned src_w);
        return addr_w - src_w;
    endfunction

    // Width of a select/counter able to hold values 0..max_val (never zero).
    function automatic int unsigned count_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/palette_mem.sv
// Single-port synchronous palette RAM: byte-enable writes, registered read data.
module palette_mem #(
    parameter  int unsigned ADDR_W = 10,
    parameter  int unsigned DATA_W = 16,
    localparam int unsigned BeW    = DATA_W / 8,
    localparam int unsigned Depth  = 2 ** ADDR_W
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BeW-1:0]    be_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [Depth];
    logic [DATA_W-1:0] rdata_q;

    // Storage array and read register; contents are deliberately never reset.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            for (int i = 0; i < BeW; i++) begin
                if (be_i[i]) begin
                    mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
        // Read register only moves on reads so write cycles leave it untouched.
        if (en_i && !we_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/palette_ram_arb.sv
// Colour-palette RAM shared between the pixel lookup path and a CPU req/ack port.
// Video normally wins the single RAM port; a CPU request that has waited MAX_WAIT
// cycles steals the next slot and the displaced pixel is flagged as dropped.
module palette_ram_arb
    import palette_pkg::*;
#(
    parameter  int unsigned ADDR_W   = DefAddrW,
    parameter  int unsigned DATA_W   = DefDataW,
    parameter  int unsigned NUM_SRC  = DefNumSrc,
    parameter  int unsigned SRC_W    = DefSrcW,
    parameter  int unsigned MAX_WAIT = DefMaxWait,
    localparam int unsigned BankW    = bank_width(ADDR_W, SRC_W),
    localparam int unsigned SelW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int unsigned BeW      = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    // Video side
    input  logic                     pix_en,
    input  logic [NUM_SRC*SRC_W-1:0] src_idx,
    input  logic [SelW-1:0]          src_sel,
    input  logic [BankW-1:0]         bank,
    input  logic                     blank,
    output logic [DATA_W-1:0]        color_out,
    output logic                     color_valid,
    output logic                     pix_dropped,
    // CPU side
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    input  logic [BeW-1:0]           cpu_be,
    output logic                     cpu_ack,
    output logic [DATA_W-1:0]        cpu_rdata
);

    localparam int unsigned CntW = count_width(MAX_WAIT);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

    // Elaboration-time parameter sanity checks.
    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("palette_ram_arb: DATA_W must be a multiple of 8");
    end
    if (ADDR_W <= SRC_W) begin : g_bad_bank_w
        $error("palette_ram_arb: ADDR_W must exceed SRC_W");
    end
    if (NUM_SRC < 1) begin : g_bad_num_src
        $error("palette_ram_arb: NUM_SRC must be at least 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    cpu_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              rd_ack_q, rd_ack_d;
    logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;

    logic              valid_q, valid_d;
    logic              dropped_q, dropped_d;
    logic              use_ram_q, use_ram_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] color_hold_q, color_hold_d;

    // ------------------------------------------------------------------
    // Arbitration and RAM port
    // ------------------------------------------------------------------
    logic              cpu_pending;
    logic              steal;
    logic              vid_grant;
    logic              cpu_grant;
    logic [SRC_W-1:0]  vid_idx;
    logic [ADDR_W-1:0] vid_addr;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    // Pick the prioritised source index; out-of-range selects fall back to source 0.
    always_comb begin
        vid_idx = src_idx[SRC_W-1:0];
        for (int k = 1; k < NUM_SRC; k++) begin
            if (src_sel == SelW'(k)) begin
                vid_idx = src_idx[k*SRC_W +: SRC_W];
            end
        end
        vid_addr = {bank, vid_idx};
    end

    // Decide who owns the RAM port this cycle: steal > pixel > CPU > idle.
    always_comb begin
        // A request in the ACK cycle is already served and must not be re-granted.
        cpu_pending = cpu_req && (state_q != StAck) && !rst;
        steal       = cpu_pending && (cnt_q == MaxCnt);
        vid_grant   = pix_en && !steal && !rst;
        cpu_grant   = cpu_pending && !vid_grant;

        mem_en   = vid_grant || cpu_grant;
        mem_we   = cpu_grant && cpu_we;
        mem_addr = cpu_grant ? cpu_addr : vid_addr;
    end

    palette_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk_i   (clk),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (cpu_wdata),
        .be_i    (cpu_be),
        .rdata_o (mem_rdata)
    );

    // ------------------------------------------------------------------
    // CPU handshake FSM next state
    // ------------------------------------------------------------------
    // Track request progress and the starvation counter.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = cpu_grant;
        rd_ack_d = cpu_grant && !cpu_we;

        case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    if (cpu_grant) begin
                        state_d = StAck;
                        cnt_d   = '0;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            StWait: begin
                if (!cpu_req) begin
                    // Request withdrawn: nothing left to serve.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cpu_grant) begin
                    state_d = StAck;
                    cnt_d   = '0;
                end else if (cnt_q != MaxCnt) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StAck: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel pipeline next state and outputs
    // ------------------------------------------------------------------
    // Remember what the result of this cycle's pixel strobe should be.
    always_comb begin
        valid_d   = pix_en;
        dropped_d = pix_en && steal;
        use_ram_d = vid_grant && !blank;
        zero_d    = pix_en && blank;
    end

    // Steer the RAM read register or the held values onto the outputs.
    always_comb begin
        if (use_ram_q) begin
            color_out = mem_rdata;
        end else if (zero_q) begin
            color_out = '0;
        end else begin
            color_out = color_hold_q;
        end
        cpu_rdata    = rd_ack_q ? mem_rdata : rdata_hold_q;
        color_valid  = valid_q;
        pix_dropped  = dropped_q;
        cpu_ack      = ack_q;
        // Hold registers capture whatever is shown so later pixel/CPU reads can't disturb it.
        color_hold_d = color_out;
        rdata_hold_d = cpu_rdata;
    end

    // Register FSM, counter, handshake outputs and pixel pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            ack_q        <= 1'b0;
            rd_ack_q     <= 1'b0;
            rdata_hold_q <= '0;
            valid_q      <= 1'b0;
            dropped_q    <= 1'b0;
            use_ram_q    <= 1'b0;
            zero_q       <= 1'b0;
            color_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            rd_ack_q     <= rd_ack_d;
            rdata_hold_q <= rdata_hold_d;
            valid_q      <= valid_d;
            dropped_q    <= dropped_d;
            use_ram_q    <= use_ram_d;
            zero_q       <= zero_d;
            color_hold_q <= color_hold_d;
        end
    end

endmodule

// File: tb/tb_palette_ram_arb.sv
// Directed bench for palette_ram_arb with 3 sources and MAX_WAIT=4, plus a randomised
// contention run checked against a small palette model.
module tb_palette_ram_arb;

    localparam int unsigned AddrW   = 10;
    localparam int unsigned DataW   = 16;
    localparam int unsigned NumSrc  = 3;
    localparam int unsigned SrcW    = 8;
    localparam int unsigned MaxWait = 4;

    logic        clk;
    logic        rst;
    logic        pix_en;
    logic [23:0] src_idx;
    logic [1:0]  src_sel;
    logic [1:0]  bank;
    logic        blank;
    logic [15:0] color_out;
    logic        color_valid;
    logic        pix_dropped;
    logic        cpu_req;
    logic        cpu_we;
    logic [9:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic [1:0]  cpu_be;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;

    palette_ram_arb #(
        .ADDR_W   (AddrW),
        .DATA_W   (DataW),
        .NUM_SRC  (NumSrc),
        .SRC_W    (SrcW),
        .MAX_WAIT (MaxWait)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .src_idx     (src_idx),
        .src_sel     (src_sel),
        .bank        (bank),
        .blank       (blank),
        .color_out   (color_out),
        .color_valid (color_valid),
        .pix_dropped (pix_dropped),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_be      (cpu_be),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    logic [15:0] model [4];
    logic        pend;
    logic        just_done;
    int          lat;
    int          pix_cnt;
    int          val_cnt;
    int          req_cnt;
    int          ack_cnt;
    logic        pe_q;
    logic        bl_q;
    logic [1:0]  idx_q;
    logic [15:0] exp_col;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One uncontended CPU access (pix_en low): ack must follow the grant cycle directly.
    task automatic cpu_op(input string tag, input logic we, input logic [9:0] a,
                          input logic [15:0] wd, input logic [1:0] be);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_be    = be;
        tick();
        check({tag, "_ack"}, 32'(cpu_ack), 1);
        cpu_req = 1'b0;
        tick();
        check({tag, "_ack_clear"}, 32'(cpu_ack), 0);
    endtask

    // Score an observed ack in the contention run against the palette model.
    task automatic take_ack();
        check("mix_ack_expected", 32'(pend), 1);
        if (pend) begin
            check("mix_ack_latency", 32'((lat + 1) <= int'(MaxWait + 2)), 1);
            if (!cpu_we) begin
                check("mix_rdata", 32'(cpu_rdata), 32'(model[cpu_addr[1:0]]));
            end else begin
                if (cpu_be[0]) model[cpu_addr[1:0]][7:0]  = cpu_wdata[7:0];
                if (cpu_be[1]) model[cpu_addr[1:0]][15:8] = cpu_wdata[15:8];
            end
            ack_cnt++;
        end
        pend      = 1'b0;
        cpu_req   = 1'b0;
        just_done = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        pend      = 1'b0;
        just_done = 1'b0;
        lat       = 0;
        pix_cnt   = 0;
        val_cnt   = 0;
        req_cnt   = 0;
        ack_cnt   = 0;

        // Reset with random video inputs and a held CPU read.
        rst       = 1'b1;
        pix_en    = 1'($urandom);
        blank     = 1'($urandom);
        src_idx   = 24'($urandom);
        src_sel   = 2'($urandom);
        bank      = 2'($urandom);
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 10'h000;
        cpu_wdata = 16'($urandom);
        cpu_be    = 2'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_color_out", 32'(color_out), 0);
            check("rst_color_valid", 32'(color_valid), 0);
            check("rst_pix_dropped", 32'(pix_dropped), 0);
            check("rst_cpu_ack", 32'(cpu_ack), 0);
            check("rst_cpu_rdata", 32'(cpu_rdata), 0);
            pix_en  = 1'($urandom);
            blank   = 1'($urandom);
            src_idx = 24'($urandom);
            src_sel = 2'($urandom);
            bank    = 2'($urandom);
        end
        pix_en = 1'b0;
        blank  = 1'b0;
        rst    = 1'b0;
        tick();
        check("rst_held_req_ack", 32'(cpu_ack), 1);
        cpu_req = 1'b0;
        tick();
        check("rst_held_req_single", 32'(cpu_ack), 0);

        // Reset while a request is blocked by video: abandoned, then served afresh.
        pix_en  = 1'b1;
        src_sel = 2'd0;
        bank    = 2'd2;
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        tick();
        check("midrst_blocked0", 32'(cpu_ack), 0);
        tick();
        check("midrst_blocked1", 32'(cpu_ack), 0);
        rst = 1'b1;
        tick();
        check("midrst_ack", 32'(cpu_ack), 0);
        check("midrst_valid", 32'(color_valid), 0);
        check("midrst_rdata", 32'(cpu_rdata), 0);
        rst    = 1'b0;
        pix_en = 1'b0;
        tick();
        check("midrst_fresh_ack", 32'(cpu_ack), 1);
        cpu_req = 1'b0;
        tick();

        // CPU write / read with byte enables.
        cpu_op("wr0", 1'b1, 10'h155, 16'hBEEF, 2'b11);
        cpu_op("rd0", 1'b0, 10'h155, 16'h0000, 2'b00);
        check("rd0_data", 32'(cpu_rdata), 'hBEEF);
        cpu_op("wr1", 1'b1, 10'h155, 16'h0012, 2'b01);
        check("rdata_held_over_write", 32'(cpu_rdata), 'hBEEF);
        cpu_op("rd1", 1'b0, 10'h155, 16'h0000, 2'b00);
        check("rd1_data", 32'(cpu_rdata), 'hBE12);
        cpu_op("wr_be0", 1'b1, 10'h155, 16'h7777, 2'b00);
        cpu_op("rd2", 1'b0, 10'h155, 16'h0000, 2'b00);
        check("be0_no_change", 32'(cpu_rdata), 'hBE12);

        // Pixel lookups, blanking and source fallback.
        cpu_op("pre0", 1'b1, 10'h23C, 16'h1234, 2'b11);
        cpu_op("pre1", 1'b1, 10'h2AA, 16'h5A5A, 2'b11);
        cpu_op("pre2", 1'b1, 10'h211, 16'h0F0F, 2'b11);
        src_idx = {8'h3C, 8'h11, 8'hAA};
        bank    = 2'd2;
        src_sel = 2'd2;
        pix_en  = 1'b1;
        tick();
        pix_en = 1'b0;
        check("pix_valid", 32'(color_valid), 1);
        check("pix_color", 32'(color_out), 'h1234);
        check("pix_not_dropped", 32'(pix_dropped), 0);
        tick();
        check("pix_valid_pulse", 32'(color_valid), 0);
        check("pix_color_hold", 32'(color_out), 'h1234);
        blank  = 1'b1;
        pix_en = 1'b1;
        tick();
        blank  = 1'b0;
        pix_en = 1'b0;
        check("blank_valid", 32'(color_valid), 1);
        check("blank_color", 32'(color_out), 0);
        src_sel = 2'd3;
        pix_en  = 1'b1;
        tick();
        check("fallback_sel3", 32'(color_out), 'h5A5A);
        src_sel = 2'd1;
        tick();
        check("sel1_color", 32'(color_out), 'h0F0F);
        src_sel = 2'd0;
        pix_en  = 1'b0;
        tick();

        // Write immediately followed by a pixel lookup of the same entry.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 10'h2AA;
        cpu_wdata = 16'hC0DE;
        cpu_be    = 2'b11;
        tick();
        check("wr_then_pix_ack", 32'(cpu_ack), 1);
        cpu_req = 1'b0;
        pix_en  = 1'b1;
        src_sel = 2'd0;
        tick();
        pix_en = 1'b0;
        check("wr_then_pix_valid", 32'(color_valid), 1);
        check("wr_then_pix_color", 32'(color_out), 'hC0DE);
        tick();

        // Starvation: four pixels serviced, then the CPU steals the fifth slot.
        pix_en   = 1'b1;
        src_sel  = 2'd2;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 10'h211;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("steal_pre_valid", 32'(color_valid), 1);
            check("steal_pre_color", 32'(color_out), 'h1234);
            check("steal_pre_dropped", 32'(pix_dropped), 0);
            check("steal_pre_ack", 32'(cpu_ack), 0);
        end
        src_sel = 2'd0;
        tick();
        check("steal_valid", 32'(color_valid), 1);
        check("steal_dropped", 32'(pix_dropped), 1);
        check("steal_color_held", 32'(color_out), 'h1234);
        check("steal_ack", 32'(cpu_ack), 1);
        check("steal_rdata", 32'(cpu_rdata), 'h0F0F);
        cpu_req = 1'b0;
        tick();
        check("post_steal_dropped", 32'(pix_dropped), 0);
        check("post_steal_color", 32'(color_out), 'hC0DE);
        check("post_steal_ack", 32'(cpu_ack), 0);
        pix_en = 1'b0;
        tick();

        // Contention run over bank 3, entries 0x300..0x303.
        for (int i = 0; i < 4; i++) begin
            model[i] = 16'(32'h1357 * (i + 1));
            cpu_op("mix_preload", 1'b1, {8'hC0, 2'(i)}, model[i], 2'b11);
        end
        exp_col = 16'hC0DE;
        bank    = 2'd3;
        for (int cyc = 0; cyc < 400; cyc++) begin
            pix_en  = ($urandom_range(9, 0) < 6);
            blank   = ($urandom_range(7, 0) == 0);
            src_idx = {6'b0, 2'($urandom), 6'b0, 2'($urandom), 6'b0, 2'($urandom)};
            src_sel = 2'($urandom);
            if (!pend && !just_done && ($urandom_range(2, 0) == 0)) begin
                pend      = 1'b1;
                lat       = 0;
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom);
                cpu_addr  = {8'hC0, 2'($urandom)};
                cpu_wdata = 16'($urandom);
                cpu_be    = 2'($urandom);
                req_cnt++;
            end
            just_done = 1'b0;
            pe_q  = pix_en;
            bl_q  = blank;
            idx_q = (src_sel < 2'd3) ? src_idx[int'(src_sel)*8 +: 2] : src_idx[1:0];
            if (pix_en) pix_cnt++;
            tick();
            if (color_valid) val_cnt++;
            if (pe_q) begin
                check("mix_valid", 32'(color_valid), 1);
                if (bl_q) exp_col = 16'h0000;
                else if (!pix_dropped) exp_col = model[idx_q];
                check("mix_color", 32'(color_out), 32'(exp_col));
            end else begin
                check("mix_idle_valid", 32'(color_valid), 0);
                check("mix_color_hold", 32'(color_out), 32'(exp_col));
            end
            check("mix_dropped_iff_steal", 32'(pix_dropped), 32'(pe_q & cpu_ack));
            if (cpu_ack) begin
                take_ack();
            end else if (pend) begin
                lat++;
                if (lat > int'(MaxWait + 2)) begin
                    check("mix_ack_timeout", 32'(cpu_ack), 1);
                    pend      = 1'b0;
                    cpu_req   = 1'b0;
                    just_done = 1'b1;
                end
            end
        end

        // Drain any outstanding request with video quiet.
        pix_en = 1'b0;
        for (int i = 0; i < 12 && pend; i++) begin
            tick();
            if (color_valid) val_cnt++;
            if (cpu_ack) take_ack();
            else lat++;
        end
        if (pend) begin
            check("drain_ack_timeout", 32'(cpu_ack), 1);
            cpu_req = 1'b0;
        end
        tick();
        if (color_valid) val_cnt++;
        check("mix_pixel_count", 32'(val_cnt), 32'(pix_cnt));
        check("mix_ack_count", 32'(ack_cnt), 32'(req_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
